l1_req_seq: RTL and testbench

- Sequencing controller for one L1 cache's CPU-side request path.
- Accepts one CPU request at a time and launches a tag/state lookup.
- Uses the lookup status to drive the downstream snoop-bus handshake: victim writeback, then RD/RFO/INV.
- Waits for the surrounding response, commits the block-state update, and returns the CPU response.
- Its state is exported as req_curSt to the combinational block-state/next-request decoder.

---
 rtl/l1_req_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_l1_req_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_req_seq.sv
// ---------------------------------------------------------------------------
// l1_req_seq -- CPU-side request sequencer for one L1 cache.
//
// Takes one CPU request at a time, strobes a tag/state lookup, then uses the
// lookup status to run the snoop-bus handshake: a posted victim writeback
// when the victim is MODIFIED, followed by RD/RFO/INV. It waits for the
// surrounding response, with a timeout and a bounded number of reissues,
// then commits the block-state update and answers the CPU. The state
// register is exported on req_curSt for the block-state/next-request
// decoder.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cpu_req_valid/ready CPU request handshake (ready only in REQ_IDLE)
//   lkup_en             one-cycle lookup strobe, same cycle as acceptance
//   lkup_done           lookup result valid (req_status, blk_curSt, init_sdreq)
//   req_status[3:0]     one-hot {wr miss, rd miss, wr hit, rd hit}
//   blk_curSt[2:0]      MESI state of the target/victim block
//   init_sdreq[2:0]     downstream request type chosen by the decoder
//   req_curSt[2:0]      sequencer state
//   sdreq_valid/type    downstream request, type held while stalled
//   sdreq_ready         downstream accept
//   sursp_valid/rsp     surrounding response
//   blk_we              one-cycle block-state/data commit strobe
//   cpu_rsp_valid/err   one-cycle CPU response; err marks retry exhaustion
//                       or an unusable lookup status
// ---------------------------------------------------------------------------
module l1_req_seq #(
    parameter int TMO_W     = 8,
    parameter int TMO_MAX   = 200,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_req_valid,
    output logic       cpu_req_ready,
    output logic       lkup_en,
    input  logic       lkup_done,
    input  logic [3:0] req_status,
    input  logic [2:0] blk_curSt,
    input  logic [2:0] init_sdreq,
    output logic [2:0] req_curSt,
    output logic       sdreq_valid,
    output logic [2:0] sdreq_type,
    input  logic       sdreq_ready,
    input  logic       sursp_valid,
    input  logic [2:0] sursp_rsp,
    output logic       blk_we,
    output logic       cpu_rsp_valid,
    output logic       cpu_rsp_err
);

    // Downstream request types
    localparam logic [2:0] SDREQ_RD  = 3'd1;
    localparam logic [2:0] SDREQ_RFO = 3'd2;
    localparam logic [2:0] SDREQ_INV = 3'd3;
    localparam logic [2:0] SDREQ_WB  = 3'd4;

    // Surrounding response codes
    localparam logic [2:0] SURSP_SNOOP = 3'd1;
    localparam logic [2:0] SURSP_FETCH = 3'd2;
    localparam logic [2:0] SURSP_OKAY  = 3'd3;

    // MESI block states
    localparam logic [2:0] MESI_I = 3'd0;
    localparam logic [2:0] MESI_S = 3'd1;
    localparam logic [2:0] MESI_E = 3'd2;
    localparam logic [2:0] MESI_M = 3'd3;

    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RTY_W-1:0] RTY_LIM  = RTY_W'(MAX_RETRY);
    // tmo_q counts completed WAIT cycles; the cycle in which the count
    // would reach TMO_MAX is the timeout cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    typedef enum logic [2:0] {
        REQ_IDLE      = 3'd0,
        REQ_LKUP      = 3'd1,
        REQ_WB        = 3'd2,
        REQ_SDREQ     = 3'd3,
        REQ_WAIT      = 3'd4,
        REQ_RSP_CURSP = 3'd5,
        REQ_ERR       = 3'd6
    } req_st_t;

    req_st_t          state, state_nxt;
    logic [2:0]       type_q;
    logic [RTY_W-1:0] rty_q;
    logic [TMO_W-1:0] tmo_q;

    logic status_ok;
    logic rd_hit, wr_hit, miss;
    logic rsp_ok;
    logic tmo_exp;

    // Exactly one status bit must be set for the lookup to be usable.
    assign status_ok = (req_status != 4'b0000) &&
                       ((req_status & (req_status - 4'd1)) == 4'b0000);
    assign rd_hit    = req_status[0];
    assign wr_hit    = req_status[1];
    assign miss      = req_status[2] | req_status[3];

    // Only a recognised response code completes the wait; anything else is
    // treated as no response and the timeout keeps running.
    assign rsp_ok  = sursp_valid &&
                     ((sursp_rsp == SURSP_SNOOP) ||
                      (sursp_rsp == SURSP_FETCH) ||
                      (sursp_rsp == SURSP_OKAY));
    assign tmo_exp = (tmo_q >= TMO_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        state_nxt     = state;
        cpu_req_ready = 1'b0;
        lkup_en       = 1'b0;
        sdreq_valid   = 1'b0;
        sdreq_type    = 3'd0;
        blk_we        = 1'b0;
        cpu_rsp_valid = 1'b0;
        cpu_rsp_err   = 1'b0;

        case (state)
            REQ_IDLE: begin
                // Gated by rst_n so ready is low while reset is held.
                cpu_req_ready = rst_n;
                if (cpu_req_valid && rst_n) begin
                    lkup_en   = 1'b1;
                    state_nxt = REQ_LKUP;
                end
            end

            REQ_LKUP: begin
                if (lkup_done) begin
                    if (!status_ok) begin
                        state_nxt = REQ_ERR;
                    end else if (rd_hit) begin
                        state_nxt = REQ_RSP_CURSP;
                    end else if (wr_hit) begin
                        // A shared line must be invalidated elsewhere first.
                        state_nxt = (blk_curSt == MESI_S) ? REQ_SDREQ : REQ_RSP_CURSP;
                    end else if (miss) begin
                        state_nxt = (blk_curSt == MESI_M) ? REQ_WB : REQ_SDREQ;
                    end else begin
                        state_nxt = REQ_ERR;
                    end
                end
            end

            REQ_WB: begin
                sdreq_valid = 1'b1;
                sdreq_type  = SDREQ_WB;
                // Writeback is posted: no response is awaited.
                if (sdreq_ready) begin
                    state_nxt = REQ_SDREQ;
                end
            end

            REQ_SDREQ: begin
                sdreq_valid = 1'b1;
                sdreq_type  = type_q;
                if (sdreq_ready) begin
                    state_nxt = REQ_WAIT;
                end
            end

            REQ_WAIT: begin
                // Response beats timeout when both land in the same cycle.
                if (rsp_ok) begin
                    state_nxt = REQ_RSP_CURSP;
                end else if (tmo_exp) begin
                    state_nxt = (rty_q < RTY_LIM) ? REQ_SDREQ : REQ_ERR;
                end
            end

            REQ_RSP_CURSP: begin
                blk_we        = 1'b1;
                cpu_rsp_valid = 1'b1;
                state_nxt     = REQ_IDLE;
            end

            REQ_ERR: begin
                cpu_rsp_valid = 1'b1;
                cpu_rsp_err   = 1'b1;
                state_nxt     = REQ_IDLE;
            end

            default: begin
                state_nxt = REQ_IDLE;
            end
        endcase
    end

    assign req_curSt = state;

    // ---------------- latched request type ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_q <= SDREQ_RD;
        end else if ((state == REQ_LKUP) && lkup_done) begin
            type_q <= init_sdreq;
        end
    end

    // ---------------- retry counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rty_q <= '0;
        end else if (state == REQ_IDLE) begin
            rty_q <= '0;
        end else if ((state == REQ_WAIT) && !rsp_ok && tmo_exp && (rty_q < RTY_LIM)) begin
            rty_q <= rty_q + 1'b1;
        end
    end

    // ---------------- timeout counter (saturating) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if ((state == REQ_SDREQ) && sdreq_ready) begin
            tmo_q <= '0;
        end else if ((state == REQ_WAIT) && (tmo_q != {TMO_W{1'b1}})) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // MESI_I and MESI_E are named for readers of the decode above; only
    // S and M steer the sequencer.
    logic unused_mesi;
    assign unused_mesi = ^{MESI_I, MESI_E, SDREQ_RFO, SDREQ_INV};

endmodule

// File: tb/tb_l1_req_seq.sv
// ---------------------------------------------------------------------------
// tb_l1_req_seq -- scoreboard bench for l1_req_seq.
// Expected CPU responses and downstream request types are queued when a
// request is driven and popped when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_l1_req_seq;

    localparam int TMO_MAX   = 6;
    localparam int MAX_RETRY = 3;

    localparam logic [2:0] SD_RD = 3'd1, SD_RFO = 3'd2, SD_INV = 3'd3, SD_WB = 3'd4;
    localparam logic [2:0] RS_SNOOP = 3'd1, RS_FETCH = 3'd2, RS_OKAY = 3'd3;
    localparam logic [2:0] M_I = 3'd0, M_S = 3'd1, M_E = 3'd2, M_M = 3'd3;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_LKUP = 3'd1, ST_WB = 3'd2, ST_SDREQ = 3'd3,
                           ST_WAIT = 3'd4, ST_RSP = 3'd5, ST_ERR = 3'd6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_req_valid = 1'b0;
    logic       cpu_req_ready;
    logic       lkup_en;
    logic       lkup_done = 1'b0;
    logic [3:0] req_status = 4'd0;
    logic [2:0] blk_curSt = 3'd0;
    logic [2:0] init_sdreq = 3'd0;
    logic [2:0] req_curSt;
    logic       sdreq_valid;
    logic [2:0] sdreq_type;
    logic       sdreq_ready = 1'b0;
    logic       sursp_valid = 1'b0;
    logic [2:0] sursp_rsp = 3'd0;
    logic       blk_we;
    logic       cpu_rsp_valid;
    logic       cpu_rsp_err;

    int errors = 0;
    int checks = 0;

    logic [1:0] rspq[$];   // {err, blk_we}
    logic [2:0] sdq[$];

    logic       sd_vld_d = 1'b0, sd_rdy_d = 1'b0;
    logic [2:0] sd_typ_d = 3'd0;

    l1_req_seq #(.TMO_W(8), .TMO_MAX(TMO_MAX), .MAX_RETRY(MAX_RETRY)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .lkup_en(lkup_en), .lkup_done(lkup_done),
        .req_status(req_status), .blk_curSt(blk_curSt), .init_sdreq(init_sdreq),
        .req_curSt(req_curSt),
        .sdreq_valid(sdreq_valid), .sdreq_type(sdreq_type), .sdreq_ready(sdreq_ready),
        .sursp_valid(sursp_valid), .sursp_rsp(sursp_rsp),
        .blk_we(blk_we), .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_err(cpu_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard pops plus stall-stability of the downstream request.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sd_vld_d && !sd_rdy_d) begin
                chk("sd_hold_v", {31'd0, sdreq_valid}, 1);
                chk("sd_hold_t", {29'd0, sdreq_type}, {29'd0, sd_typ_d});
            end
            if (sdreq_valid && sdreq_ready) begin
                if (sdq.size() == 0) chk("sd_unexp", {29'd0, sdreq_type}, 0);
                else                 chk("sd_type", {29'd0, sdreq_type}, {29'd0, sdq.pop_front()});
            end
            if (cpu_rsp_valid) begin
                if (rspq.size() == 0) chk("rsp_unexp", {30'd0, cpu_rsp_err, blk_we}, 32'hff);
                else                  chk("rsp_err_we", {30'd0, cpu_rsp_err, blk_we}, {30'd0, rspq.pop_front()});
            end
            sd_vld_d <= sdreq_valid;
            sd_rdy_d <= sdreq_ready;
            sd_typ_d <= sdreq_type;
        end else begin
            sd_vld_d <= 1'b0;
            sd_rdy_d <= 1'b0;
            sd_typ_d <= 3'd0;
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 of the
    // first cycle after the lookup resolves.
    task automatic issue(input logic [3:0] st, input logic [2:0] blk,
                         input logic [2:0] init, input int lk_wait);
        cpu_req_valid = 1'b1;
        req_status    = st;
        blk_curSt     = blk;
        init_sdreq    = init;
        @(negedge clk);
        chk("acc_rdy", {31'd0, cpu_req_ready}, 1);
        chk("acc_lkup", {31'd0, lkup_en}, 1);
        tick();
        cpu_req_valid = 1'b0;
        @(negedge clk);
        chk("lkup_st", {29'd0, req_curSt}, {29'd0, ST_LKUP});
        chk("busy_rdy", {30'd0, cpu_req_ready, lkup_en}, 0);
        for (int i = 0; i < lk_wait; i++) begin
            tick();
            @(negedge clk);
            chk("lkup_hold", {29'd0, req_curSt}, {29'd0, ST_LKUP});
        end
        lkup_done = 1'b1;
        tick();
        lkup_done  = 1'b0;
        init_sdreq = 3'd7;   // latched value must be used from here on
        blk_curSt  = M_I;
    endtask

    logic [11:0] outs;
    assign outs = {cpu_req_ready, lkup_en, sdreq_valid, sdreq_type, blk_we,
                   cpu_rsp_valid, cpu_rsp_err, req_curSt};

    initial begin
        int n;
        // ---- reset state ----
        #2;
        chk("rst_outs", {20'd0, outs}, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_st", {29'd0, req_curSt}, {29'd0, ST_IDLE});
        chk("rst_rdy", {31'd0, cpu_req_ready}, 1);
        tick();

        // ---- read hit, E, immediate lookup: response on cycle 2 ----
        rspq.push_back(2'b01);
        issue(4'b0001, M_E, SD_RD, 0);
        @(negedge clk);
        chk("rh_st", {29'd0, req_curSt}, {29'd0, ST_RSP});
        chk("rh_lat", {31'd0, cpu_rsp_valid}, 1);
        chk("rh_nosd", {31'd0, sdreq_valid}, 0);
        tick();

        // ---- write hit, E: no downstream traffic ----
        rspq.push_back(2'b01);
        issue(4'b0010, M_E, SD_RFO, 1);
        @(negedge clk);
        chk("whe_st", {29'd0, req_curSt}, {29'd0, ST_RSP});
        tick();

        // ---- write hit, S: INV with 3-cycle stall, response after 5 cycles ----
        sdq.push_back(SD_INV);
        rspq.push_back(2'b01);
        issue(4'b0010, M_S, SD_INV, 0);
        @(negedge clk);
        chk("whs_st", {29'd0, req_curSt}, {29'd0, ST_SDREQ});
        repeat (3) tick();
        sdreq_ready = 1'b1;
        tick();
        sdreq_ready = 1'b0;
        repeat (4) tick();
        sursp_valid = 1'b1;
        sursp_rsp   = RS_OKAY;
        tick();
        sursp_valid = 1'b0;
        @(negedge clk);
        chk("whs_done", {30'd0, blk_we, cpu_rsp_valid}, 2'b11);
        tick();

        // ---- write miss, M victim: WB then RFO, FETCH response ----
        sdq.push_back(SD_WB);
        sdq.push_back(SD_RFO);
        rspq.push_back(2'b01);
        issue(4'b1000, M_M, SD_RFO, 2);
        @(negedge clk);
        chk("wm_wb_st", {29'd0, req_curSt}, {29'd0, ST_WB});
        tick();   // one cycle of WB stall
        sdreq_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("wm_sd_st", {29'd0, req_curSt}, {29'd0, ST_SDREQ});
        tick();
        sdreq_ready = 1'b0;
        sursp_valid = 1'b1;
        sursp_rsp   = RS_FETCH;
        tick();
        sursp_valid = 1'b0;
        @(negedge clk);
        chk("wm_rsp1", {29'd0, req_curSt}, {29'd0, ST_RSP});
        tick();
        @(negedge clk);
        chk("wm_rsp_idle", {29'd0, req_curSt}, {29'd0, ST_IDLE});
        tick();

        // ---- read miss, no response: 1 + MAX_RETRY issues then error ----
        for (int r = 0; r <= MAX_RETRY; r++) sdq.push_back(SD_RD);
        rspq.push_back(2'b10);
        issue(4'b0100, M_I, SD_RD, 0);
        sursp_valid = 1'b1;   // stray response outside WAIT
        sursp_rsp   = RS_OKAY;
        tick();
        sursp_valid = 1'b0;
        @(negedge clk);
        chk("stray_ign", {29'd0, req_curSt}, {29'd0, ST_SDREQ});
        for (int r = 0; r <= MAX_RETRY; r++) begin
            sdreq_ready = 1'b1;
            tick();
            sdreq_ready = 1'b0;
            n = 0;
            do begin
                tick();
                n++;
            end while (req_curSt == ST_WAIT && n < 20);
            chk("tmo_len", n, TMO_MAX);
            chk("tmo_next", {29'd0, req_curSt}, (r < MAX_RETRY) ? {29'd0, ST_SDREQ} : {29'd0, ST_ERR});
        end
        @(negedge clk);
        chk("tmo_err", {30'd0, cpu_rsp_err, blk_we}, 2'b10);
        tick();

        // ---- response on the timeout cycle wins (retry counter was cleared) ----
        sdq.push_back(SD_RD);
        rspq.push_back(2'b01);
        issue(4'b0100, M_E, SD_RD, 0);
        sdreq_ready = 1'b1;
        tick();
        sdreq_ready = 1'b0;
        repeat (TMO_MAX - 1) tick();
        sursp_valid = 1'b1;
        sursp_rsp   = RS_SNOOP;
        tick();
        sursp_valid = 1'b0;
        @(negedge clk);
        chk("tie_rsp", {29'd0, req_curSt}, {29'd0, ST_RSP});
        tick();

        // ---- multi-hot and zero status go to error ----
        rspq.push_back(2'b10);
        issue(4'b0011, M_E, SD_RD, 0);
        @(negedge clk);
        chk("mh_err", {29'd0, req_curSt}, {29'd0, ST_ERR});
        tick();
        rspq.push_back(2'b10);
        issue(4'b0000, M_E, SD_RD, 0);
        @(negedge clk);
        chk("zero_err", {29'd0, req_curSt}, {29'd0, ST_ERR});
        tick();

        // ---- reset in the middle of WAIT: no response, outputs drop ----
        sdq.push_back(SD_RFO);
        issue(4'b1000, M_S, SD_RFO, 0);
        sdreq_ready = 1'b1;
        tick();
        sdreq_ready = 1'b0;
        tick();
        chk("pre_rst_wait", {29'd0, req_curSt}, {29'd0, ST_WAIT});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {20'd0, outs}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_st", {29'd0, req_curSt}, {29'd0, ST_IDLE});
        chk("post_rst_rdy", {31'd0, cpu_req_ready}, 1);
        tick();

        // ---- normal traffic after reset ----
        rspq.push_back(2'b01);
        issue(4'b0001, M_S, SD_RD, 0);
        @(negedge clk);
        chk("post_rst_rh", {29'd0, req_curSt}, {29'd0, ST_RSP});
        tick();
        repeat (2) tick();

        chk("rspq_empty", rspq.size(), 0);
        chk("sdq_empty", sdq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
